// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive sequencer.
// Packet lengths are in unstuffed bits and include PID and CRC.
package usb_rx_pkg;

  localparam int PKT_W  = 99;
  localparam int BCNT_W = 7;
  localparam int TMO_W  = 8;

  localparam logic [BCNT_W-1:0] LEN_HS    = 7'd19;
  localparam logic [BCNT_W-1:0] LEN_TOKEN = 7'd35;
  localparam logic [BCNT_W-1:0] LEN_DATA  = 7'd99;
  localparam logic [BCNT_W-1:0] BCNT_MAX  = 7'd127;

  localparam logic [TMO_W-1:0] IDLE_MAX  = 8'd255;
  localparam logic [TMO_W-1:0] FLUSH_MAX = 8'd100;

  typedef enum logic [2:0] {
    OK      = 3'd0,
    TIMEOUT = 3'd1,
    LENERR  = 3'd2,
    PIDERR  = 3'd3,
    DECTMO  = 3'd4,
    ABORT   = 3'd5
  } rx_status_t;

  typedef enum logic [1:0] {
    KIND_HS    = 2'd0,
    KIND_TOKEN = 2'd1,
    KIND_DATA  = 2'd2,
    KIND_RSVD  = 2'd3
  } rx_kind_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    LISTEN = 3'd2,
    FEED   = 3'd3,
    FLUSH  = 3'd4,
    RESP   = 3'd5
  } rx_state_t;

  function automatic logic [BCNT_W-1:0] pkt_len(input rx_kind_t kind);
    case (kind)
      KIND_HS:    return LEN_HS;
      KIND_TOKEN: return LEN_TOKEN;
      KIND_DATA:  return LEN_DATA;
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/usb_rx_ctrl_tmo_counter.sv
// Cycle counter that stops at a programmable limit and flags it; one-cycle clear.
// Expired is combinational from the count, so it is valid in the cycle the limit is reached.
module rx_tmo_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         expired
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != limit)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == limit);

endmodule

// File: rtl/usb_rx_ctrl.sv
// Sequences one received packet into the CRC/PID decoder and reports a result code.
// Bits pass through with zero latency; no backpressure, the decoder takes every forwarded bit.
module usb_rx_ctrl
  import usb_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       expectKind,
  input  logic             abort,
  input  logic             bitIn,
  input  logic             bitValid,
  input  logic             eop,
  output logic             decRst_b,
  output logic             decBitIn,
  output logic             decBitInAvail,
  output logic             decDone,
  input  logic             decPktOutAvail,
  input  logic             decValid,
  input  logic [PKT_W-1:0] decPkt,
  output logic             busy,
  output logic             respValid,
  output rx_status_t       respStatus,
  output logic [PKT_W-1:0] respPkt
);

  rx_state_t         state, state_nxt;
  rx_kind_t          kind_q;
  rx_status_t        status_nxt, done_status, resp_status_q;
  logic [BCNT_W-1:0] bit_cnt, len;
  logic [PKT_W-1:0]  resp_pkt_q;
  logic              capture_pkt;
  logic              bit_take;
  logic              tmo_clear, tmo_en, tmo_expired;
  logic [TMO_W-1:0]  tmo_limit, tmo_cnt;

  assign len = pkt_len(kind_q);

  // A bit is accepted in LISTEN/FEED unless the same cycle aborts the packet.
  assign bit_take = ((state == LISTEN) || (state == FEED)) && bitValid && !abort;

  // One counter serves both waits; any state change restarts it.
  assign tmo_clear = (state_nxt != state);
  assign tmo_en    = (state == LISTEN) || (state == FLUSH);
  assign tmo_limit = (state == FLUSH) ? FLUSH_MAX : IDLE_MAX;

  rx_tmo_counter #(.W(TMO_W)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .limit   (tmo_limit),
    .count   (tmo_cnt),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    done_status = OK;
    if (bit_cnt != len) begin
      done_status = LENERR;
    end else if ((kind_q != KIND_HS) && !decValid) begin
      done_status = PIDERR;
    end
  end

  always_comb begin
    state_nxt   = state;
    status_nxt  = resp_status_q;
    capture_pkt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (rx_kind_t'(expectKind) == KIND_RSVD) begin
            state_nxt  = RESP;
            status_nxt = LENERR;
          end else begin
            state_nxt = ARM;
          end
        end
      end
      ARM: begin
        if (abort) begin
          state_nxt  = RESP;
          status_nxt = ABORT;
        end else begin
          state_nxt = LISTEN;
        end
      end
      LISTEN: begin
        if (abort) begin
          state_nxt  = RESP;
          status_nxt = ABORT;
        end else if (bitValid) begin
          state_nxt = eop ? FLUSH : FEED;
        end else if (tmo_expired) begin
          state_nxt  = RESP;
          status_nxt = TIMEOUT;
        end else if (eop) begin
          state_nxt  = RESP;
          status_nxt = LENERR;
        end
      end
      FEED: begin
        if (abort) begin
          state_nxt  = RESP;
          status_nxt = ABORT;
        end else if (eop) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (abort) begin
          state_nxt  = RESP;
          status_nxt = ABORT;
        end else if (decPktOutAvail) begin
          state_nxt   = RESP;
          status_nxt  = done_status;
          capture_pkt = 1'b1;
        end else if (tmo_expired) begin
          state_nxt  = RESP;
          status_nxt = DECTMO;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q        <= KIND_HS;
      bit_cnt       <= '0;
      resp_status_q <= OK;
      resp_pkt_q    <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        kind_q <= rx_kind_t'(expectKind);
      end
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (bit_take && (bit_cnt != BCNT_MAX)) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if ((state_nxt == RESP) && (state != RESP)) begin
        resp_status_q <= status_nxt;
      end
      if (capture_pkt) begin
        resp_pkt_q <= decPkt;
      end
    end
  end

  // Outputs are forced to their reset values for the whole reset cycle.
  always_comb begin
    busy          = !rst && (state != IDLE);
    decRst_b      = !rst && (state != ARM);
    decBitIn      = bitIn;
    decBitInAvail = !rst && bit_take && (bit_cnt < len);
    decDone       = !rst && (state == FLUSH) && (tmo_cnt == '0);
    respValid     = !rst && (state == RESP);
    respStatus    = resp_status_q;
    respPkt       = resp_pkt_q;
  end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed scoreboard bench for usb_rx_ctrl; a monitor pops expected results on respValid.
module tb_usb_rx_ctrl;
  import usb_rx_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       expectKind = 2'd0;
  logic             abort = 1'b0;
  logic             bitIn = 1'b0;
  logic             bitValid = 1'b0;
  logic             eop = 1'b0;
  logic             decRst_b, decBitIn, decBitInAvail, decDone;
  logic             decPktOutAvail = 1'b0;
  logic             decValid = 1'b0;
  logic [PKT_W-1:0] decPkt = '0;
  logic             busy, respValid;
  rx_status_t       respStatus;
  logic [PKT_W-1:0] respPkt;

  usb_rx_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .expectKind     (expectKind),
    .abort          (abort),
    .bitIn          (bitIn),
    .bitValid       (bitValid),
    .eop            (eop),
    .decRst_b       (decRst_b),
    .decBitIn       (decBitIn),
    .decBitInAvail  (decBitInAvail),
    .decDone        (decDone),
    .decPktOutAvail (decPktOutAvail),
    .decValid       (decValid),
    .decPkt         (decPkt),
    .busy           (busy),
    .respValid      (respValid),
    .respStatus     (respStatus),
    .respPkt        (respPkt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    rx_status_t       st;
    logic [PKT_W-1:0] pkt;
  } exp_t;

  exp_t             exp_q[$];
  int               checks = 0;
  int               failures = 0;
  int               n_avail = 0;
  int               n_done = 0;
  logic [PKT_W-1:0] last_pkt = '0;

  task automatic chk(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pops plus decoder strobe counters.
  always @(negedge clk) begin
    if (!rst) begin
      if (decBitInAvail) n_avail++;
      if (decDone) n_done++;
      if (respValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp status=%0d", respStatus);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_status", PKT_W'(respStatus), PKT_W'(e.st));
          chk("resp_pkt", respPkt, e.pkt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input rx_status_t st, input logic [PKT_W-1:0] pkt);
    exp_t e;
    e.st  = st;
    e.pkt = pkt;
    exp_q.push_back(e);
  endtask

  // Returns with the DUT in LISTEN (or RESP for the reserved kind).
  task automatic start_pkt(input logic [1:0] kind);
    start = 1'b1;
    expectKind = kind;
    tick();
    start = 1'b0;
    if (kind != 2'd3) begin
      @(negedge clk);
      chk("arm_decrst_b", PKT_W'(decRst_b), PKT_W'(0));
      chk("arm_busy", PKT_W'(busy), PKT_W'(1));
      tick();
    end
  endtask

  task automatic send_bits(input int n, input logic with_eop);
    for (int i = 0; i < n; i++) begin
      bitValid = 1'b1;
      bitIn    = (i % 3 == 0);
      eop      = with_eop && (i == n - 1);
      tick();
    end
    bitValid = 1'b0;
    bitIn    = 1'b0;
    eop      = 1'b0;
  endtask

  // Counts negedges up to and including the one showing respValid.
  task automatic wait_resp(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!respValid && n < budget);
    if (!respValid) begin
      checks++;
      failures++;
      $display("FAIL resp_wait actual=none required=respValid within %0d", budget);
    end
    tick();
  endtask

  // Pulse decoder completion in the delay-th FLUSH cycle and collect the result.
  task automatic finish_pkt(input int delay, input logic valid, input logic [PKT_W-1:0] pkt,
                            input rx_status_t st);
    int n;
    push(st, pkt);
    last_pkt = pkt;
    repeat (delay - 1) tick();
    decPktOutAvail = 1'b1;
    decValid       = valid;
    decPkt         = pkt;
    tick();
    decPktOutAvail = 1'b0;
    decValid       = 1'b0;
    wait_resp(20, n);
    chk("resp_after_avail", PKT_W'(n), PKT_W'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0, n;
    logic [PKT_W-1:0] pa, pb, pc, pd, pe;
    pa = {3'b101, 32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D};
    pb = {3'b011, 32'h0BADF00D, 32'hFEEDFACE, 32'h55AA33CC};
    pc = {3'b110, 32'h11112222, 32'h33334444, 32'h55556666};
    pd = {3'b001, 32'h89ABCDEF, 32'h01234567, 32'hA5A5A5A5};
    pe = {3'b111, 32'h77778888, 32'h9999AAAA, 32'hBBBBCCCC};

    // Reset values while rst is held.
    tick();
    @(negedge clk);
    chk("rst_busy", PKT_W'(busy), PKT_W'(0));
    chk("rst_respvalid", PKT_W'(respValid), PKT_W'(0));
    chk("rst_avail", PKT_W'(decBitInAvail), PKT_W'(0));
    chk("rst_done", PKT_W'(decDone), PKT_W'(0));
    chk("rst_decrst_b", PKT_W'(decRst_b), PKT_W'(0));
    chk("rst_status", PKT_W'(respStatus), PKT_W'(OK));
    chk("rst_pkt", respPkt, PKT_W'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_decrst_b", PKT_W'(decRst_b), PKT_W'(1));
    tick();

    // Token, 35 bits, eop on the last; a stray start in LISTEN must not relatch the kind.
    a0 = n_avail; d0 = n_done;
    start_pkt(2'd1);
    start = 1'b1; expectKind = 2'd0;
    tick();
    start = 1'b0;
    send_bits(35, 1'b1);
    finish_pkt(16, 1'b1, pa, OK);
    chk("token_avail_cnt", PKT_W'(n_avail - a0), PKT_W'(35));
    chk("token_done_cnt", PKT_W'(n_done - d0), PKT_W'(1));

    // Data, 99 bits, decoder answers after 81 cycles.
    a0 = n_avail; d0 = n_done;
    start_pkt(2'd2);
    send_bits(99, 1'b1);
    finish_pkt(81, 1'b1, pb, OK);
    chk("data_avail_cnt", PKT_W'(n_avail - a0), PKT_W'(99));
    chk("data_done_cnt", PKT_W'(n_done - d0), PKT_W'(1));

    // Data with decoder silent: FLUSH cycles 1..101 then RESP, respPkt holds.
    d0 = n_done;
    start_pkt(2'd2);
    send_bits(99, 1'b1);
    push(DECTMO, last_pkt);
    wait_resp(200, n);
    chk("dectmo_latency", PKT_W'(n), PKT_W'(102));
    chk("dectmo_done_cnt", PKT_W'(n_done - d0), PKT_W'(1));

    // Handshake overrun: 21 bits sent, only 19 forwarded.
    a0 = n_avail;
    start_pkt(2'd0);
    send_bits(21, 1'b1);
    finish_pkt(3, 1'b0, pc, LENERR);
    chk("hs_avail_cnt", PKT_W'(n_avail - a0), PKT_W'(19));

    // Token with PID not recognised.
    start_pkt(2'd1);
    send_bits(35, 1'b1);
    finish_pkt(5, 1'b0, pd, PIDERR);

    // No bits: ARM is negedge 1, LISTEN 2..257, RESP on 258.
    push(TIMEOUT, last_pkt);
    start = 1'b1; expectKind = 2'd1;
    tick();
    start = 1'b0;
    wait_resp(300, n);
    chk("timeout_latency", PKT_W'(n), PKT_W'(258));

    // Abort together with eop in FEED.
    a0 = n_avail; d0 = n_done;
    start_pkt(2'd2);
    send_bits(5, 1'b0);
    push(ABORT, last_pkt);
    abort = 1'b1; eop = 1'b1;
    tick();
    abort = 1'b0; eop = 1'b0;
    wait_resp(20, n);
    chk("abort_latency", PKT_W'(n), PKT_W'(1));
    chk("abort_done_cnt", PKT_W'(n_done - d0), PKT_W'(0));
    chk("abort_avail_cnt", PKT_W'(n_avail - a0), PKT_W'(5));

    // eop in LISTEN with zero bits.
    d0 = n_done;
    start_pkt(2'd1);
    push(LENERR, last_pkt);
    eop = 1'b1;
    tick();
    eop = 1'b0;
    wait_resp(20, n);
    chk("eop0_latency", PKT_W'(n), PKT_W'(1));
    chk("eop0_done_cnt", PKT_W'(n_done - d0), PKT_W'(0));

    // Reserved kind goes straight to RESP.
    push(LENERR, last_pkt);
    start_pkt(2'd3);
    wait_resp(20, n);
    chk("rsvd_latency", PKT_W'(n), PKT_W'(1));

    // Reset at bit 10 of a data packet, then a normal handshake.
    start_pkt(2'd2);
    send_bits(10, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", PKT_W'(busy), PKT_W'(0));
    chk("midrst_decrst_b", PKT_W'(decRst_b), PKT_W'(0));
    chk("midrst_avail", PKT_W'(decBitInAvail), PKT_W'(0));
    tick();
    rst = 1'b0;
    last_pkt = '0;
    @(negedge clk);
    chk("postrst_busy", PKT_W'(busy), PKT_W'(0));
    chk("postrst_respvalid", PKT_W'(respValid), PKT_W'(0));
    chk("postrst_status", PKT_W'(respStatus), PKT_W'(OK));
    chk("postrst_pkt", respPkt, PKT_W'(0));
    tick();
    a0 = n_avail;
    start_pkt(2'd0);
    send_bits(19, 1'b1);
    finish_pkt(4, 1'b0, pe, OK);
    chk("postrst_hs_avail", PKT_W'(n_avail - a0), PKT_W'(19));

    repeat (3) tick();
    chk("scoreboard_empty", PKT_W'(exp_q.size()), PKT_W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_rx_ctrl.md
USB_RX_CTRL -- requirements
Module: usb_rx_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 rst  in  1  reset; one clock, synchronous and active-high.
REQ-003 start  in  1  one-cycle pulse: arm reception; ignored unless IDLE.
REQ-004 expect  in  2  packet kind latched at start: 0 handshake, 1 token, 2 data; 3 reserved.
REQ-005 abort  in  1  cancel the current reception.
REQ-006 bitIn / bitValid / eop  in  1/1/1  unstuffed serial bit, its qualifier, end-of-packet marker.
REQ-007 decRst_b  out  1  active-low reset to the CRC decoder.
REQ-008 decBitIn / decBitInAvail / decDone  out  1/1/1  bit stream and done strobe to the decoder.
REQ-009 decPktOutAvail / decValid  in  1/1  decoder completion strobe and PID-recognised flag.
REQ-010 decPkt  in  99  decoder packet register.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 respValid  out  1  one-cycle result strobe.
REQ-013 respStatus  out  3  result code (rx_status_t).
REQ-014 respPkt  out  99  decPkt captured at completion.

Function
REQ-015 States: IDLE, ARM, LISTEN, FEED, FLUSH, RESP.
REQ-016 IDLE->ARM on start (expect latched); start while busy has no effect.
REQ-017 ARM lasts exactly 1 cycle with decRst_b=0, then LISTEN; decRst_b=1 in all other non-reset states.
REQ-018 LISTEN: first bitValid forwards the bit and enters FEED; bitCount becomes 1.
REQ-019 FEED: decBitInAvail=bitValid, decBitIn=bitIn, same cycle, zero latency, while bitCount < LEN[expect].
REQ-020 Bits beyond LEN[expect] are not forwarded; bitCount continues, saturating at 127.
REQ-021 eop in FEED: a coincident valid bit is forwarded and counted first, then go to FLUSH.
REQ-022 FLUSH: decDone=1 for exactly the first FLUSH cycle; decPktOutAvail in that cycle or later ends FLUSH.
REQ-023 On decPktOutAvail: respPkt<=decPkt; status = LENERR if bitCount != LEN[expect]; else PIDERR if expect!=0 and decValid=0; else OK; go to RESP.
REQ-024 FLUSH exceeding FLUSH_MAX=100 cycles without decPktOutAvail -> DECTMO, go to RESP.
REQ-025 LISTEN exceeding IDLE_MAX=255 cycles without bitValid -> TIMEOUT, go to RESP.
REQ-026 eop in LISTEN (zero bits) -> LENERR, go to RESP without pulsing decDone.
REQ-027 abort in ARM/LISTEN/FEED/FLUSH -> ABORT, go to RESP; abort beats timeout beats eop in the same cycle.
REQ-028 RESP: respValid=1 for 1 cycle, then IDLE; respStatus/respPkt hold until the next RESP.
REQ-029 expect=3 at start -> ARM skipped, immediate RESP with LENERR.
REQ-030 One shared 8-bit cycle counter serves LISTEN and FLUSH timeouts; it is cleared on every state entry.

Reset
REQ-031 While rst=1: state IDLE; busy, respValid, decBitInAvail, decDone = 0; decRst_b = 0; respStatus = OK; respPkt, counters = 0.
REQ-032 rst mid-reception discards all progress; no respValid is generated for the aborted packet.

Structure
REQ-033 Package usb_rx_pkg holds rx_status_t (OK=0, TIMEOUT=1, LENERR=2, PIDERR=3, DECTMO=4, ABORT=5), rx_kind_t, LEN_HS=19, LEN_TOKEN=35, LEN_DATA=99, IDLE_MAX, FLUSH_MAX.
REQ-034 One sub-module: rx_tmo_counter (clear, enable, limit, expired flag).

Verification
REQ-035 Token: start, expect=1, 35 bits, eop with last bit, decPktOutAvail 16 cycles later, decValid=1 -> one respValid, OK, respPkt=decPkt.
REQ-036 Data: 99 bits, eop; 81 cycles to decPktOutAvail -> OK. Hold decPktOutAvail low for 101 cycles -> DECTMO.
REQ-037 Handshake with 21 bits -> only 19 decBitInAvail pulses, LENERR.
REQ-038 Token with decValid=0 -> PIDERR. No bitValid for 256 cycles -> TIMEOUT at cycle 256.
REQ-039 abort and eop in the same FEED cycle -> ABORT, decDone never pulsed.
REQ-040 rst asserted at bit 10 of a data packet -> all outputs at reset values the next cycle, no respValid; start then accepted normally.
